// File: rtl/alu_op_sequencer.sv
// MIPS ALU control with valid/ready handshakes and registered outputs.
// SLL/SRL requests are expanded into shamt single-bit shift beats for a 1-bit-shift ALU.
module alu_op_sequencer #(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int OPER_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPER_W-1:0]  alu_operation,
  output logic               shift_step,
  output logic               step_last,
  output logic               busy,
  output logic               jr_detect,
  output logic               illegal
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SHIFT} state_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_LUI  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_ILL  = 4'd15;

  state_t               r_state;
  logic                 r_out_valid, r_shift_step, r_step_last, r_busy, r_jr, r_illegal;
  logic [OPER_W-1:0]    r_alu_operation;
  logic [SHAMT_W-1:0]   r_remaining;

  state_t               w_state_nx;
  logic                 w_out_valid_nx, w_shift_step_nx, w_step_last_nx, w_busy_nx, w_jr_nx, w_illegal_nx;
  logic [OPER_W-1:0]    w_alu_operation_nx;
  logic [SHAMT_W-1:0]   w_remaining_nx;

  logic [3:0]           w_code;
  logic                 w_is_shift, w_jr, w_illegal;

  assign in_ready = (r_state == ST_IDLE) && !reset;

  // Request decode; illegal encodings take priority over every other attribute.
  always_comb begin
    w_code     = OP_ADD;
    w_is_shift = 1'b0;
    w_jr       = 1'b0;
    w_illegal  = 1'b0;
    unique case (alu_op[2:0])
      3'b000:  w_code = OP_ADD;
      3'b001:  w_code = OP_OR;
      3'b010:  w_code = OP_AND;
      3'b011:  w_code = OP_ADD;
      3'b100:  w_code = OP_SUB;
      3'b101:  w_code = OP_LUI;
      3'b110:  w_illegal = 1'b1;
      default: begin
        if (|(funct >> 6)) begin
          w_illegal = 1'b1;
        end else begin
          case (funct[5:0])
            6'h20:   w_code = OP_ADD;
            6'h22:   w_code = OP_SUB;
            6'h24:   w_code = OP_AND;
            6'h25:   w_code = OP_OR;
            6'h27:   w_code = OP_NOR;
            6'h00:   begin w_code = OP_SLL;  w_is_shift = 1'b1; end
            6'h02:   begin w_code = OP_SRL;  w_is_shift = 1'b1; end
            6'h08:   begin w_code = OP_PASS; w_jr = 1'b1; end
            default: w_illegal = 1'b1;
          endcase
        end
      end
    endcase
    if (|(alu_op >> 3)) w_illegal = 1'b1;
    if (w_illegal) begin
      w_code     = OP_ILL;
      w_is_shift = 1'b0;
      w_jr       = 1'b0;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nx         = r_state;
    w_out_valid_nx     = r_out_valid;
    w_alu_operation_nx = r_alu_operation;
    w_shift_step_nx    = r_shift_step;
    w_step_last_nx     = r_step_last;
    w_busy_nx          = r_busy;
    w_jr_nx            = r_jr;
    w_illegal_nx       = r_illegal;
    w_remaining_nx     = r_remaining;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          w_out_valid_nx  = 1'b1;
          w_busy_nx       = 1'b1;
          w_jr_nx         = w_jr;
          w_illegal_nx    = w_illegal;
          w_remaining_nx  = shamt;
          if (w_is_shift && (shamt != '0)) begin
            w_state_nx         = ST_SHIFT;
            w_alu_operation_nx = OPER_W'(w_code);
            w_shift_step_nx    = 1'b1;
            w_step_last_nx     = (shamt == SHAMT_W'(1));
          end else begin
            w_state_nx         = ST_ISSUE;
            w_alu_operation_nx = w_is_shift ? OPER_W'(OP_PASS) : OPER_W'(w_code);
            w_shift_step_nx    = 1'b0;
            w_step_last_nx     = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          w_state_nx         = ST_IDLE;
          w_out_valid_nx     = 1'b0;
          w_alu_operation_nx = '0;
          w_shift_step_nx    = 1'b0;
          w_step_last_nx     = 1'b0;
          w_busy_nx          = 1'b0;
          w_jr_nx            = 1'b0;
          w_illegal_nx       = 1'b0;
          w_remaining_nx     = '0;
        end
      end
      default: begin
        if (out_ready) begin
          if (r_remaining == SHAMT_W'(1)) begin
            w_state_nx         = ST_IDLE;
            w_out_valid_nx     = 1'b0;
            w_alu_operation_nx = '0;
            w_shift_step_nx    = 1'b0;
            w_step_last_nx     = 1'b0;
            w_busy_nx          = 1'b0;
            w_jr_nx            = 1'b0;
            w_illegal_nx       = 1'b0;
            w_remaining_nx     = '0;
          end else begin
            w_remaining_nx = r_remaining - SHAMT_W'(1);
            w_step_last_nx = (r_remaining == SHAMT_W'(2));
          end
        end
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_out_valid     <= 1'b0;
      r_alu_operation <= '0;
      r_shift_step    <= 1'b0;
      r_step_last     <= 1'b0;
      r_busy          <= 1'b0;
      r_jr            <= 1'b0;
      r_illegal       <= 1'b0;
      r_remaining     <= '0;
    end else begin
      r_state         <= w_state_nx;
      r_out_valid     <= w_out_valid_nx;
      r_alu_operation <= w_alu_operation_nx;
      r_shift_step    <= w_shift_step_nx;
      r_step_last     <= w_step_last_nx;
      r_busy          <= w_busy_nx;
      r_jr            <= w_jr_nx;
      r_illegal       <= w_illegal_nx;
      r_remaining     <= w_remaining_nx;
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_operation = r_alu_operation;
  assign shift_step    = r_shift_step;
  assign step_last     = r_step_last;
  assign busy          = r_busy;
  assign jr_detect     = r_jr;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer: decode, shift sequencing, backpressure, reset.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic       in_ready, out_valid, shift_step, step_last, busy, jr_detect, illegal;
  logic [3:0] alu_operation;

  logic       in_valid4;
  logic [3:0] alu_op4;
  logic       in_ready4, out_valid4, shift_step4, step_last4, busy4, jr_detect4, illegal4;
  logic [3:0] alu_operation4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .alu_operation(alu_operation),
    .shift_step(shift_step), .step_last(step_last), .busy(busy),
    .jr_detect(jr_detect), .illegal(illegal)
  );

  alu_op_sequencer #(.ALUOP_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .alu_op(alu_op4), .funct(funct), .shamt(shamt),
    .out_valid(out_valid4), .out_ready(out_ready), .alu_operation(alu_operation4),
    .shift_step(shift_step4), .step_last(step_last4), .busy(busy4),
    .jr_detect(jr_detect4), .illegal(illegal4)
  );

  // Observed bundle: {out_valid, busy, alu_operation, shift_step, step_last, jr, illegal, in_ready}
  logic [10:0] obs;
  assign obs = {out_valid, busy, alu_operation, shift_step, step_last, jr_detect, illegal, in_ready};

  function automatic logic [10:0] exp_o(input logic v, input logic b, input logic [3:0] c,
                                        input logic ss, input logic sl, input logic jr,
                                        input logic il, input logic rdy);
    return {v, b, c, ss, sl, jr, il, rdy};
  endfunction

  localparam logic [10:0] IDLE_O = 11'b000000000_01;

  // Drives one request on the negedge so it is accepted at the following posedge.
  task automatic drive_req(input logic [2:0] a, input logic [5:0] f, input logic [4:0] s);
    @(negedge clk);
    alu_op = a; funct = f; shamt = s; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; alu_op = 3'b000; funct = 6'h20; shamt = '0;
    out_ready = 1'b1; in_valid4 = 1'b0; alu_op4 = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 11'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h want=%h", i, obs, 11'b0);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", obs, IDLE_O);
    end
  endtask

  task automatic test_decode_sweep();
    logic [2:0] t_op [0:10] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                                3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    logic [5:0] t_fn [0:10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27,
                                6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    logic [3:0] t_cd [0:10] = '{4'd3, 4'd4, 4'd0, 4'd1, 4'd2,
                                4'd3, 4'd1, 4'd0, 4'd3, 4'd4, 4'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive_req(t_op[i], t_fn[i], 5'd9);
      checks++;
      if (obs !== IDLE_O) begin
        failures++;
        $display("FAIL decode_pre[%0d] got=%h want=%h", i, obs, IDLE_O);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (obs !== exp_o(1, 1, t_cd[i], 0, 1, 0, 0, 0)) begin
        failures++;
        $display("FAIL decode[%0d] got=%h want=%h", i, obs, exp_o(1, 1, t_cd[i], 0, 1, 0, 0, 0));
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL decode_end got=%h want=%h", obs, IDLE_O);
    end
  endtask

  task automatic run_shift(input logic [5:0] f, input logic [4:0] n, input logic [3:0] code);
    out_ready = 1'b1;
    drive_req(3'b111, f, n);
    for (int k = 1; k <= int'(n); k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (obs !== exp_o(1, 1, code, 1, (k == int'(n)), 0, 0, 0)) begin
        failures++;
        $display("FAIL shift_n%0d_beat%0d got=%h want=%h", n, k, obs,
                 exp_o(1, 1, code, 1, (k == int'(n)), 0, 0, 0));
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL shift_n%0d_end got=%h want=%h", n, obs, IDLE_O);
    end
  endtask

  task automatic test_shift();
    run_shift(6'h00, 5'd5, 4'd6);
    run_shift(6'h02, 5'd31, 4'd7);
    drive_req(3'b111, 6'h00, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_o(1, 1, 4'd8, 0, 1, 0, 0, 0)) begin
      failures++;
      $display("FAIL shift_zero got=%h want=%h", obs, exp_o(1, 1, 4'd8, 0, 1, 0, 0, 0));
    end
    @(negedge clk);
    checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL shift_zero_end got=%h want=%h", obs, IDLE_O);
    end
  endtask

  task automatic test_backpressure();
    logic       rdy_seq  [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       last_seq [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    drive_req(3'b111, 6'h02, 5'd3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_ready = rdy_seq[c];
      if (c == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1; alu_op = 3'b000; funct = 6'h20; shamt = 5'd7;
      end
      checks++;
      if (obs !== exp_o(1, 1, 4'd7, 1, last_seq[c], 0, 0, 0)) begin
        failures++;
        $display("FAIL bp_cycle%0d got=%h want=%h", c, obs, exp_o(1, 1, 4'd7, 1, last_seq[c], 0, 0, 0));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL bp_end got=%h want=%h", obs, IDLE_O);
    end
  endtask

  task automatic test_special();
    drive_req(3'b111, 6'h08, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_o(1, 1, 4'd8, 0, 1, 1, 0, 0)) begin
      failures++;
      $display("FAIL jr got=%h want=%h", obs, exp_o(1, 1, 4'd8, 0, 1, 1, 0, 0));
    end
    // Illegal alu_op held through a two-cycle stall.
    drive_req(3'b110, 6'h20, 5'd0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = (c == 2);
      checks++;
      if (obs !== exp_o(1, 1, 4'd15, 0, 1, 0, 1, 0)) begin
        failures++;
        $display("FAIL illegal_op110[%0d] got=%h want=%h", c, obs, exp_o(1, 1, 4'd15, 0, 1, 0, 1, 0));
      end
    end
    drive_req(3'b111, 6'h3F, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_o(1, 1, 4'd15, 0, 1, 0, 1, 0)) begin
      failures++;
      $display("FAIL illegal_funct3f got=%h want=%h", obs, exp_o(1, 1, 4'd15, 0, 1, 0, 1, 0));
    end
    @(negedge clk);
    alu_op4 = 4'b1000; funct = 6'h20; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    checks++;
    if ({out_valid4, alu_operation4, illegal4, step_last4, jr_detect4} !== {1'b1, 4'd15, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL aluop4_upper got=%b want=%b", {out_valid4, alu_operation4, illegal4, step_last4, jr_detect4},
               {1'b1, 4'd15, 1'b1, 1'b1, 1'b0});
    end
    @(negedge clk);
    alu_op4 = 4'b0111; funct = 6'h22; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    checks++;
    if ({out_valid4, alu_operation4, illegal4, step_last4} !== {1'b1, 4'd4, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL aluop4_sub got=%b want=%b", {out_valid4, alu_operation4, illegal4, step_last4},
               {1'b1, 4'd4, 1'b0, 1'b1});
    end
    @(negedge clk);
    checks++;
    if (obs !== IDLE_O) begin
      failures++;
      $display("FAIL special_end got=%h want=%h", obs, IDLE_O);
    end
  endtask

  task automatic test_reset_mid_shift();
    out_ready = 1'b1;
    drive_req(3'b111, 6'h00, 5'd10);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 5) reset = 1'b1;
      checks++;
      if (obs !== exp_o(1, 1, 4'd6, 1, 0, 0, 0, 0)) begin
        failures++;
        $display("FAIL rst_mid_beat%0d got=%h want=%h", k, obs, exp_o(1, 1, 4'd6, 1, 0, 0, 0, 0));
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== 11'b0) begin
      failures++;
      $display("FAIL rst_mid_cleared got=%h want=%h", obs, 11'b0);
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== IDLE_O) begin
        failures++;
        $display("FAIL rst_mid_quiet[%0d] got=%h want=%h", c, obs, IDLE_O);
      end
    end
    drive_req(3'b000, 6'h00, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs !== exp_o(1, 1, 4'd3, 0, 1, 0, 0, 0)) begin
      failures++;
      $display("FAIL rst_mid_add got=%h want=%h", obs, exp_o(1, 1, 4'd3, 0, 1, 0, 0, 0));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_shift();
    test_backpressure();
    test_special();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
